// File: rtl/rv_mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, grant pointer
// and the registered shared-bus command payload.
package rv_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D
    } arb_state_t;

    typedef enum logic {
        MASTER_INSTR = 1'b0,
        MASTER_DATA  = 1'b1
    } arb_master_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } mem_cmd_t;

    // Fetches are always full-word reads.
    function automatic mem_cmd_t instr_cmd(input logic [ADDR_W-1:0] addr);
        mem_cmd_t c;
        c.write = 1'b0;
        c.addr  = addr;
        c.wdata = '0;
        c.sel   = '1;
        return c;
    endfunction

    function automatic mem_cmd_t data_cmd(input logic              write,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wdata,
                                          input logic [SEL_W-1:0]  sel);
        mem_cmd_t c;
        c.write = write;
        c.addr  = addr;
        c.wdata = wdata;
        c.sel   = sel;
        return c;
    endfunction

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Bundle of fetch, load/store and shared memory bus signals around the arbiter.
// slave = arbiter view, master = core/memory view.
interface rv_mem_arbiter_if;
    import rv_mem_arbiter_pkg::*;

    logic              i_instr_req;
    logic [ADDR_W-1:0] i_instr_addr;
    logic              o_instr_ack;
    logic [DATA_W-1:0] o_instr_data;

    logic              i_data_req;
    logic              i_data_write;
    logic [ADDR_W-1:0] i_data_addr;
    logic [DATA_W-1:0] i_data_wdata;
    logic [SEL_W-1:0]  i_data_sel;
    logic              o_data_ack;
    logic [DATA_W-1:0] o_data_rdata;

    logic              o_mem_req;
    logic              o_mem_write;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [SEL_W-1:0]  o_mem_sel;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_bus_error;

    modport slave (
        input  i_instr_req, i_instr_addr,
        input  i_data_req, i_data_write, i_data_addr, i_data_wdata, i_data_sel,
        input  i_mem_ack, i_mem_rdata,
        output o_instr_ack, o_instr_data,
        output o_data_ack, o_data_rdata,
        output o_mem_req, o_mem_write, o_mem_addr, o_mem_wdata, o_mem_sel,
        output o_bus_error
    );

    modport master (
        output i_instr_req, i_instr_addr,
        output i_data_req, i_data_write, i_data_addr, i_data_wdata, i_data_sel,
        output i_mem_ack, i_mem_rdata,
        input  o_instr_ack, o_instr_data,
        input  o_data_ack, o_data_rdata,
        input  o_mem_req, o_mem_write, o_mem_addr, o_mem_wdata, o_mem_sel,
        input  o_bus_error
    );

endinterface

// File: rtl/rv_arb_watchdog.sv
// Grant-cycle watchdog: counts unacknowledged grant cycles and flags the
// cycle in which the grant has used up its budget.
module rv_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count k-1 during grant cycle k, so expiry lands on cycle TIMEOUT_CYCLES.
    assign o_expire_c = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and
// load/store, with a per-grant watchdog that forces termination of hung cycles.
module rv_mem_arbiter
    import rv_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    rv_mem_arbiter_if.slave  bus
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    arb_master_t r_last;
    arb_master_t w_last_nxt;
    mem_cmd_t    r_cmd;
    mem_cmd_t    w_cmd_nxt;
    logic        r_mem_req;
    logic        w_mem_req_nxt;

    logic        w_granted;
    logic        w_expire;
    logic        w_done;
    logic        w_pick_data;

    assign w_granted = (r_state != ARB_IDLE);
    assign w_done    = w_granted && (bus.i_mem_ack || w_expire);

    // On a tie the master that did not win last time takes the bus.
    assign w_pick_data = bus.i_data_req && (!bus.i_instr_req || (r_last == MASTER_INSTR));

    rv_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (!w_granted),
        .i_enable   (w_granted && !bus.i_mem_ack),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ARB_IDLE;
            r_last    <= MASTER_INSTR;
            r_cmd     <= '0;
            r_mem_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cmd     <= w_cmd_nxt;
            r_mem_req <= w_mem_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_cmd_nxt     = r_cmd;
        w_mem_req_nxt = r_mem_req;

        case (r_state)
            ARB_IDLE: begin
                if (bus.i_instr_req || bus.i_data_req) begin
                    w_mem_req_nxt = 1'b1;
                    if (w_pick_data) begin
                        w_state_nxt = ARB_GRANT_D;
                        w_cmd_nxt   = data_cmd(bus.i_data_write, bus.i_data_addr,
                                               bus.i_data_wdata, bus.i_data_sel);
                    end else begin
                        w_state_nxt = ARB_GRANT_I;
                        w_cmd_nxt   = instr_cmd(bus.i_instr_addr);
                    end
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                // Command stays frozen until the cycle completes or times out.
                if (w_done) begin
                    w_state_nxt   = ARB_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_last_nxt    = (r_state == ARB_GRANT_D) ? MASTER_DATA : MASTER_INSTR;
                end
            end
            default: begin
                w_state_nxt   = ARB_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign bus.o_mem_req    = r_mem_req;
    assign bus.o_mem_write  = r_cmd.write;
    assign bus.o_mem_addr   = r_cmd.addr;
    assign bus.o_mem_wdata  = r_cmd.wdata;
    assign bus.o_mem_sel    = r_cmd.sel;

    // Completion is a same-cycle pass-through of the memory ack (or expiry).
    assign bus.o_instr_ack  = (r_state == ARB_GRANT_I) && (bus.i_mem_ack || w_expire);
    assign bus.o_data_ack   = (r_state == ARB_GRANT_D) && (bus.i_mem_ack || w_expire);
    assign bus.o_bus_error  = w_granted && w_expire && !bus.i_mem_ack;

    assign bus.o_instr_data = bus.i_mem_rdata;
    assign bus.o_data_rdata = bus.i_mem_rdata;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed and randomized checks of rv_mem_arbiter against a grant-level
// reference model (owner, grant age, last winner).
module tb_rv_mem_arbiter;
    import rv_mem_arbiter_pkg::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_mem_arbiter_if bus();

    rv_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the bus, how many grant cycles it has used.
    int          m_owner;   // -1 none, 0 instr, 1 data
    int          m_age;
    int          m_last;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic        p_rst, p_ireq, p_dreq, p_mack;
    logic        e_iack = 1'b0;
    logic        e_dack = 1'b0;
    int          acks[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (p_rst || rst) begin
            m_owner = -1;
            m_last  = 0;
            m_age   = 0;
        end else if (m_owner >= 0) begin
            if (p_mack || m_age == T) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else if (p_ireq || p_dreq) begin
            m_owner = (p_ireq && p_dreq) ? (1 - m_last) : (p_dreq ? 1 : 0);
            m_age   = 1;
            if (m_owner == 1) begin
                m_write = bus.i_data_write;
                m_addr  = bus.i_data_addr;
                m_wdata = bus.i_data_wdata;
                m_sel   = bus.i_data_sel;
            end else begin
                m_write = 1'b0;
                m_addr  = bus.i_instr_addr;
                m_wdata = 32'h0;
                m_sel   = 4'hF;
            end
        end
    endtask

    task automatic check_all();
        logic timed, exp_req, exp_err;
        timed   = (m_owner >= 0) && (m_age == T);
        exp_req = !rst && (m_owner >= 0);
        e_iack  = !rst && (m_owner == 0) && (bus.i_mem_ack || timed);
        e_dack  = !rst && (m_owner == 1) && (bus.i_mem_ack || timed);
        exp_err = !rst && timed && !bus.i_mem_ack;
        chk("mem_req",   32'(bus.o_mem_req),   32'(exp_req));
        chk("instr_ack", 32'(bus.o_instr_ack), 32'(e_iack));
        chk("data_ack",  32'(bus.o_data_ack),  32'(e_dack));
        chk("bus_error", 32'(bus.o_bus_error), 32'(exp_err));
        chk("instr_data", bus.o_instr_data, bus.i_mem_rdata);
        chk("data_rdata", bus.o_data_rdata, bus.i_mem_rdata);
        if (exp_req) begin
            chk("mem_write", 32'(bus.o_mem_write), 32'(m_write));
            chk("mem_addr",  bus.o_mem_addr,       m_addr);
            chk("mem_wdata", bus.o_mem_wdata,      m_wdata);
            chk("mem_sel",   32'(bus.o_mem_sel),   32'(m_sel));
        end else if (rst) begin
            chk("rst_mem_fields", {bus.o_mem_addr[31:5] | bus.o_mem_wdata[31:5],
                                   bus.o_mem_sel, bus.o_mem_write}, 32'h0);
        end
        if (bus.o_instr_ack === 1'b1) acks.push_back(0);
        if (bus.o_data_ack === 1'b1)  acks.push_back(1);
        p_rst  = rst;
        p_ireq = bus.i_instr_req;
        p_dreq = bus.i_data_req;
        p_mack = bus.i_mem_ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // mack: 0/1 literal, 2 = ack whenever the model says a grant is active.
    task automatic cyc(input logic ireq, input logic dreq, input int mack, input logic [31:0] rdata);
        tick();
        bus.i_instr_req = ireq;
        bus.i_data_req  = dreq;
        bus.i_mem_ack   = (mack == 2) ? (m_owner >= 0) : (mack == 1);
        bus.i_mem_rdata = rdata;
        @(negedge clk);
        check_all();
    endtask

    task automatic set_data(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        bus.i_data_write = w;
        bus.i_data_addr  = a;
        bus.i_data_wdata = wd;
        bus.i_data_sel   = s;
    endtask

    initial begin
        int  lat;
        bit  iact, dact;
        lat = T + 1;
        iact = 1'b0;
        dact = 1'b0;
        rst = 1'b1;
        bus.i_instr_req = 1'b0; bus.i_instr_addr = 32'h0;
        bus.i_data_req = 1'b0;
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        bus.i_mem_ack = 1'b0; bus.i_mem_rdata = 32'h0;
        m_owner = -1; m_age = 0; m_last = 0;
        m_write = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_sel = 4'h0;
        p_rst = 1'b1; p_ireq = 1'b0; p_dreq = 1'b0; p_mack = 1'b0;

        // Reset state, memory ack while held in reset
        cyc(1'b0, 1'b0, 1, 32'h1234_5678);
        chk("rst_mem_req", 32'(bus.o_mem_req), 32'h0);
        chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
        tick(); rst = 1'b0; bus.i_mem_ack = 1'b0;
        @(negedge clk); check_all();

        // Stray memory ack in IDLE is ignored
        cyc(1'b0, 1'b0, 1, $urandom);
        chk("idle_ack_ignored", 32'(bus.o_instr_ack | bus.o_data_ack), 32'h0);

        // Single fetch
        bus.i_instr_addr = 32'h0000_0100;
        cyc(1'b1, 1'b0, 0, $urandom);
        cyc(1'b1, 1'b0, 0, $urandom);
        chk("fetch_addr", bus.o_mem_addr, 32'h0000_0100);
        chk("fetch_sel", 32'(bus.o_mem_sel), 32'hF);
        chk("fetch_write", 32'(bus.o_mem_write), 32'h0);
        cyc(1'b1, 1'b0, 0, $urandom);
        cyc(1'b1, 1'b0, 1, 32'h0000_0013);
        chk("fetch_ack", 32'(bus.o_instr_ack), 32'h1);
        chk("fetch_data", bus.o_instr_data, 32'h0000_0013);
        chk("fetch_no_dack", 32'(bus.o_data_ack), 32'h0);
        cyc(1'b0, 1'b0, 0, $urandom);
        chk("fetch_idle", 32'(bus.o_mem_req | bus.o_instr_ack), 32'h0);

        // Store
        set_data(1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011);
        cyc(1'b0, 1'b1, 0, $urandom);
        cyc(1'b0, 1'b1, 0, $urandom);
        chk("store_addr", bus.o_mem_addr, 32'h2000_0004);
        chk("store_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
        chk("store_sel", 32'(bus.o_mem_sel), 32'h3);
        chk("store_write", 32'(bus.o_mem_write), 32'h1);
        cyc(1'b0, 1'b1, 1, $urandom);
        chk("store_ack", 32'(bus.o_data_ack), 32'h1);
        cyc(1'b0, 1'b0, 0, $urandom);

        // Simultaneous requests from reset: data, instr, data, instr ...
        tick(); rst = 1'b1; @(negedge clk); check_all();
        tick(); rst = 1'b0; @(negedge clk); check_all();
        set_data(1'b0, 32'h0000_4000, 32'h0, 4'hF);
        bus.i_instr_addr = 32'h0000_0200;
        acks.delete();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 2, $urandom);
        cyc(1'b0, 1'b0, 0, $urandom);
        chk("tie_count", 32'(acks.size()), 32'd6);
        if (acks.size() >= 4) begin
            chk("tie_order0", 32'(acks[0]), 32'd1);
            chk("tie_order1", 32'(acks[1]), 32'd0);
            chk("tie_order2", 32'(acks[2]), 32'd1);
            chk("tie_order3", 32'(acks[3]), 32'd0);
        end

        // Timeout on a data read, then a clean fetch
        set_data(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        cyc(1'b0, 1'b1, 0, $urandom);
        for (int i = 0; i < T - 1; i++) cyc(1'b0, 1'b1, 0, $urandom);
        cyc(1'b0, 1'b1, 0, $urandom);
        chk("to_dack", 32'(bus.o_data_ack), 32'h1);
        chk("to_error", 32'(bus.o_bus_error), 32'h1);
        cyc(1'b0, 1'b0, 0, $urandom);
        chk("to_idle", 32'(bus.o_mem_req | bus.o_bus_error), 32'h0);
        cyc(1'b1, 1'b0, 0, $urandom);
        cyc(1'b1, 1'b0, 1, 32'h0000_0042);
        chk("after_to_iack", 32'(bus.o_instr_ack), 32'h1);
        chk("after_to_noerr", 32'(bus.o_bus_error), 32'h0);
        cyc(1'b0, 1'b0, 0, $urandom);

        // Ack lands exactly on the expiry cycle
        cyc(1'b0, 1'b1, 0, $urandom);
        for (int i = 0; i < T - 1; i++) cyc(1'b0, 1'b1, 0, $urandom);
        cyc(1'b0, 1'b1, 1, 32'hCAFE_F00D);
        chk("exp_ack", 32'(bus.o_data_ack), 32'h1);
        chk("exp_noerr", 32'(bus.o_bus_error), 32'h0);
        chk("exp_rdata", bus.o_data_rdata, 32'hCAFE_F00D);
        cyc(1'b0, 1'b0, 0, $urandom);

        // Asynchronous reset in the middle of a data grant
        cyc(1'b0, 1'b1, 0, $urandom);
        cyc(1'b0, 1'b1, 0, $urandom);
        tick();
        bus.i_mem_ack = 1'b1;
        #1;
        chk("pre_rst_dack", 32'(bus.o_data_ack), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_drop_req", 32'(bus.o_mem_req), 32'h0);
        chk("rst_drop_acks", 32'(bus.o_data_ack | bus.o_instr_ack), 32'h0);
        bus.i_mem_ack = 1'b0;
        bus.i_instr_req = 1'b1;
        @(negedge clk); check_all();
        tick(); rst = 1'b0; @(negedge clk); check_all();
        cyc(1'b1, 1'b1, 2, $urandom);
        chk("post_rst_data_first", 32'(bus.o_data_ack), 32'h1);
        chk("post_rst_no_iack", 32'(bus.o_instr_ack), 32'h0);
        cyc(1'b0, 1'b0, 0, $urandom);

        // Randomized traffic with random memory latency (T+1 = never acks)
        for (int i = 0; i < 800; i++) begin
            tick();
            if (m_owner >= 0 && m_age == 1) lat = $urandom_range(1, T + 1);
            if (e_iack) iact = 1'b0;
            if (e_dack) dact = 1'b0;
            if (!iact && $urandom_range(0, 2) == 0) begin
                iact = 1'b1;
                bus.i_instr_addr = $urandom;
            end
            if (!dact && $urandom_range(0, 2) == 0) begin
                dact = 1'b1;
                set_data(1'($urandom), $urandom, $urandom, 4'($urandom));
            end
            bus.i_instr_req = iact;
            bus.i_data_req  = dact;
            bus.i_mem_ack   = (m_owner >= 0) ? (m_age == lat) : ($urandom_range(0, 3) == 0);
            bus.i_mem_rdata = $urandom;
            @(negedge clk);
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
